nibble_serial_add_ctrl: RTL and testbench
=========================================

// Module: nibble_serial_add_ctrl
// PURPOSE
//  Sequences one shared 4-bit ripple-adder slice to add two wide operands one nibble per cycle, LSB nibble first.
//  Carry is chained between nibbles in a register.
//  Sits between a requester (valid/ready) and the adder datapath.
//  Trades latency for area versus a full-width ripple adder.
// PARAMETERS
//  NIBBLES  4  number of 4-bit slices; operand width W = 4*NIBBLES (16 by default); legal range 1..16
// PORTS
//  clk        in   1    single clock, rising edge
//  rst        in   1    synchronous, active-high reset
//  req_valid  in   1    requester presents operands
//  req_ready  out  1    controller can accept a request (IDLE state)
//  a_in       in   W    operand A, sampled on accept
//  b_in       in   W    operand B, sampled on accept
//  cin_in     in   1    carry-in to nibble 0, sampled on accept
//  sum_out    out  W    result, valid while done_valid=1
//  cout_out   out  1    carry-out of top nibble, valid while done_valid=1
//  done_valid out  1    result available
//  done_ack   in   1    consumer takes result
//  busy       out  1    1 in RUN state
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=1, busy=0, done_valid=0, sum_out=0, cout_out=0, nibble index=0, carry reg=0.
//  Accept: req_valid & req_ready at an edge.
//    - Latch a_in, b_in into shift regs; latch cin_in into carry reg.
//    - Clear sum reg; go to RUN.
//  RUN, cycle k (k=0..NIBBLES-1):
//    - Slice adds A[4k+3:4k] + B[4k+3:4k] + carry.
//    - Writes sum nibble k; carry reg <= slice cout.
//    - On k=NIBBLES-1: cout_out <= slice cout; go to DONE.
//  DONE: done_valid=1; sum_out/cout_out held stable until done_ack.
//  done_ack in DONE -> IDLE next edge; done_valid drops that edge.
//  Latency: accept edge to done_valid=1 is exactly NIBBLES+1 edges (5 for default).
//  Back-to-back: req_ready rises the edge after ack.
//    - No same-cycle ack+accept bypass.
//    - Throughput: one add per NIBBLES+2 cycles, minimum.
//  req_valid while not ready: ignored; a_in/b_in are not re-sampled.
//    - Requester must hold request until ready.
//  done_ack outside DONE: ignored.
//  Overflow: sum wraps mod 2^W; the carry appears only on cout_out.
//  Nibble index wraps to 0 on leaving RUN.
//  rst mid-RUN or mid-DONE: abandons the operation; all outputs return to reset values next edge; no done pulse.
//  Outputs registered except req_ready and busy, which decode state registers only (no input-to-output comb path).
// STRUCTURE
//  Package adder_pkg:
//    - ST_IDLE/ST_RUN/ST_DONE state encoding (2-bit)
//    - SLICE_W=4
//    - idx width function clog2(NIBBLES)
//  Sub-module nibble_adder:
//    - Combinational 4-bit ripple adder, single instance.
//    - Ports a[3:0], b[3:0], cin -> s[3:0], cout.
//  Controller holds FSM, index counter, operand shift regs (shift right 4 per RUN cycle), sum shift reg, carry reg.
// TESTING  (NIBBLES=4)
//  0x0001+0xFFFF, cin=0 -> sum=0x0000, cout=1; done_valid exactly 5 edges after accept.
//  0x0F0F+0x00F1, cin=1 -> sum=0x1001, cout=0; checks carry across nibbles 0->1 and 2->3.
//  0xFFFF+0x0000, cin=1 -> sum=0x0000, cout=1; checks full ripple from cin through all nibbles.
//  Hold done_ack=0 for 10 cycles -> result and done_valid stable; new req_valid ignored, req_ready=0.
//  Assert rst in RUN cycle 2 -> next edge idle outputs all zero, req_ready=1; next add 0x1234+0x1111 -> 0x2345.
//  Random 1000 back-to-back requests, ack after 0-3 cycles -> {cout,sum} == a+b+cin; accept spacing >= 6 cycles.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder controller.
//   SLICE_W   : width of the shared adder slice
//   state_e   : controller FSM encoding (2-bit)
//   idx_width : width of the nibble index counter for a given nibble count
package adder_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // clog2 of the nibble count, never narrower than one bit so NIBBLES=1 still has a counter.
  function automatic int unsigned idx_width(input int unsigned nibbles);
    return (nibbles <= 1) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/nibble_adder.sv
// Combinational 4-bit ripple-carry adder slice.
//   a, b : slice operands
//   cin  : carry into bit 0
//   s    : slice sum
//   cout : carry out of bit 3
module nibble_adder
  import adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic [SLICE_W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[SLICE_W];
  end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Adds two W-bit operands (W = 4*NIBBLES) through a single shared 4-bit adder slice,
// one nibble per cycle, LSB nibble first, chaining the carry through a register.
//   clk, rst             : clock, synchronous active-high reset
//   req_valid/req_ready  : request handshake; a_in, b_in, cin_in sampled on accept
//   sum_out, cout_out    : result, held while done_valid is high
//   done_valid/done_ack  : result handshake
//   busy                 : high while nibbles are being added
module nibble_serial_add_ctrl
  import adder_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [SLICE_W*NIBBLES-1:0] a_in,
  input  logic [SLICE_W*NIBBLES-1:0] b_in,
  input  logic                       cin_in,
  output logic [SLICE_W*NIBBLES-1:0] sum_out,
  output logic                       cout_out,
  output logic                       done_valid,
  input  logic                       done_ack,
  output logic                       busy
);

  localparam int unsigned W    = SLICE_W * NIBBLES;
  localparam int unsigned IdxW = idx_width(NIBBLES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [W-1:0]      sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;

  logic [SLICE_W-1:0] slice_s;
  logic               slice_cout;
  logic [W-1:0]       sum_shift;

  // Operand shift registers always present their current nibble at the bottom.
  nibble_adder u_slice (
    .a    (a_q[SLICE_W-1:0]),
    .b    (b_q[SLICE_W-1:0]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // New nibble enters at the top; after NIBBLES shifts nibble 0 sits at the bottom.
  if (NIBBLES == 1) begin : g_single
    assign sum_shift = slice_s;
  end else begin : g_multi
    assign sum_shift = {slice_s, sum_q[W-1:SLICE_W]};
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = cin_in;
          sum_d   = '0;
          cout_d  = 1'b0;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> SLICE_W;
        b_d     = b_q >> SLICE_W;
        sum_d   = sum_shift;
        carry_d = slice_cout;
        if (idx_q == LastIdx) begin
          cout_d  = slice_cout;
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (done_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  // All outputs come straight from registers or a decode of the state register.
  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_RUN);
  assign done_valid = (state_q == ST_DONE);
  assign sum_out    = sum_q;
  assign cout_out   = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
module tb_nibble_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic        cin_in = 1'b0;
  logic [15:0] sum_out;
  logic        cout_out;
  logic        done_valid;
  logic        done_ack = 1'b0;
  logic        busy;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  int accept_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .cin_in     (cin_in),
    .sum_out    (sum_out),
    .cout_out   (cout_out),
    .done_valid (done_valid),
    .done_ack   (done_ack),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for req_ready, then presents one request for exactly the accept edge.
  task automatic start(input logic [15:0] a, input logic [15:0] b, input logic c);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    a_in = a; b_in = b; cin_in = c; req_valid = 1'b1;
    @(posedge clk); #1;
    accept_cyc = cyc;
    req_valid = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("ready_low_in_run", {31'd0, req_ready}, 32'd0);
  endtask

  // Counts edges after the accept edge until done_valid; 4 more edges means NIBBLES+1 in total.
  task automatic wait_done(input string tag);
    int n = 0;
    while (!done_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, n, 32'd4);
  endtask

  task automatic ack();
    done_ack = 1'b1;
    @(posedge clk); #1;
    done_ack = 1'b0;
    check("done_drop_on_ack", {31'd0, done_valid}, 32'd0);
    check("ready_after_ack", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic add_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic c, input logic [15:0] exp_s, input logic exp_c);
    start(a, b, c);
    wait_done({tag, "_latency"});
    check({tag, "_sum"}, {16'd0, sum_out}, {16'd0, exp_s});
    check({tag, "_cout"}, {31'd0, cout_out}, {31'd0, exp_c});
    ack();
  endtask

  initial begin
    logic [16:0] exp17;
    logic [15:0] ra, rb;
    logic        rc;
    int          prev_accept;
    int          d;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done_valid}, 32'd0);
    check("rst_sum", {16'd0, sum_out}, 32'd0);
    check("rst_cout", {31'd0, cout_out}, 32'd0);

    // done_ack while idle must do nothing.
    done_ack = 1'b1;
    @(posedge clk); #1;
    done_ack = 1'b0;
    check("idle_ack_ready", {31'd0, req_ready}, 32'd1);
    check("idle_ack_done", {31'd0, done_valid}, 32'd0);

    add_check("v1", 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1);
    add_check("v2", 16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0);
    add_check("v3", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);

    // Hold the result for 10 cycles while a new request is waved at the controller.
    start(16'hABCD, 16'h1234, 1'b0);
    wait_done("hold_latency");
    a_in = 16'hFFFF; b_in = 16'hFFFF; cin_in = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_done", {31'd0, done_valid}, 32'd1);
      check("hold_sum", {16'd0, sum_out}, 32'h0000BE01);
      check("hold_cout", {31'd0, cout_out}, 32'd0);
      check("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    ack();

    // Reset sampled at the edge that would run nibble 2.
    start(16'h5555, 16'h1111, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_ready", {31'd0, req_ready}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done_valid}, 32'd0);
    check("midrst_sum", {16'd0, sum_out}, 32'd0);
    check("midrst_cout", {31'd0, cout_out}, 32'd0);
    add_check("post_rst", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);

    // Back-to-back requests with a 0..3 cycle ack delay.
    prev_accept = -100;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      rc = 1'($urandom_range(0, 1));
      exp17 = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      start(ra, rb, rc);
      if (i > 0) check("rand_spacing", {31'd0, (accept_cyc - prev_accept) >= 6}, 32'd1);
      prev_accept = accept_cyc;
      wait_done("rand_latency");
      d = $urandom_range(0, 3);
      repeat (d) begin
        @(posedge clk); #1;
      end
      check("rand_result", {15'd0, cout_out, sum_out}, {15'd0, exp17});
      ack();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
